// File: rtl/mac_pipe_sched.sv
// -----------------------------------------------------------------------------
// mac_pipe_sched
//
// Issue scheduler for the shared multiply/accumulate datapath
// (Booth partial-product generation -> Wallace tree -> final adder/normalize).
// Two requesters share the datapath. They are arbitrated round-robin and at
// most one operation is issued per cycle. The datapath registers hold only
// data. This block tracks the valid bit, tag and source of every in-flight
// operation and drives the stage enables and the result handshake.
//
// Parameters
//   PARM_MANT    mantissa width of the datapath (reported only, no control use)
//   PARM_STAGES  datapath register stages from issue to result (>= 1)
//   PARM_TAG_W   requester tag width
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous reset, active-high
//   req0_valid_i  requester 0 has an operation
//   req0_tag_i    requester 0 tag
//   req0_ready_o  requester 0 accepted this cycle
//   req1_valid_i  requester 1 has an operation
//   req1_tag_i    requester 1 tag
//   req1_ready_o  requester 1 accepted this cycle
//   dp_sel_o      operand mux select (0=req0, 1=req1), meaningful with dp_issue_o
//   dp_issue_o    load the stage-0 datapath registers with the selected operands
//   stage_en_o    per-stage register enable, bit k = stage k
//   res_valid_o   result register holds a valid result
//   res_ready_i   consumer accepts the result
//   res_tag_o     tag of the result
//   res_src_o     requester that issued the result
//   flush_i       (only with MAC_SCHED_FLUSH_EN) discard all in-flight ops
//   busy_o        any stage holds a valid operation
//
// Build option
//   MAC_SCHED_FLUSH_EN  adds flush_i. A flush clears every stage valid bit on
//                       the next edge, blocks issue for the cycle and takes
//                       priority over a result stall. Without the macro the
//                       pipeline is cleared only by rst_i.
// -----------------------------------------------------------------------------
module mac_pipe_sched #(
    parameter int PARM_MANT   = 23,
    parameter int PARM_STAGES = 3,
    parameter int PARM_TAG_W  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req0_valid_i,
    input  logic [PARM_TAG_W-1:0]  req0_tag_i,
    output logic                   req0_ready_o,
    input  logic                   req1_valid_i,
    input  logic [PARM_TAG_W-1:0]  req1_tag_i,
    output logic                   req1_ready_o,
    output logic                   dp_sel_o,
    output logic                   dp_issue_o,
    output logic [PARM_STAGES-1:0] stage_en_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [PARM_TAG_W-1:0]  res_tag_o,
    output logic                   res_src_o,
`ifdef MAC_SCHED_FLUSH_EN
    input  logic                   flush_i,
`endif
    output logic                   busy_o
);

    // Elaboration-time sanity check on the configuration.
    if (PARM_STAGES < 1 || PARM_MANT < 1 || PARM_TAG_W < 1) begin : g_bad_cfg
        $error("mac_pipe_sched: PARM_STAGES, PARM_MANT and PARM_TAG_W must be >= 1");
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    logic [PARM_STAGES-1:0] vld_q;
    logic [PARM_TAG_W-1:0]  tag_q [PARM_STAGES];
    logic [PARM_STAGES-1:0] src_q;
    logic                   rr_ptr_q;

    logic                   flush_w;
    logic                   stall;
    logic                   adv;
    logic                   grant;
    logic                   any_req;
    logic                   issue;
    logic [PARM_TAG_W-1:0]  grant_tag;
    logic [PARM_STAGES-1:0] vld_shift;

`ifdef MAC_SCHED_FLUSH_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    // The whole pipe freezes while the last stage holds an unaccepted result;
    // there is no bubble collapsing.
    assign stall = vld_q[PARM_STAGES-1] & ~res_ready_i;
    assign adv   = ~stall;

    // Round-robin: a lone requester always wins, contention goes to rr_ptr.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = rr_ptr_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    assign any_req   = req0_valid_i | req1_valid_i;
    assign grant_tag = grant ? req1_tag_i : req0_tag_i;

    // Issue is gated with rst_i so that every output reads 0 while reset is
    // held, even when requesters keep their valid lines up.
    assign issue = ~rst_i & ~flush_w & adv & any_req;

    // Stage-0 valid bit enters at the bottom; the generate handles the
    // single-stage case where there is nothing to shift.
    if (PARM_STAGES == 1) begin : g_shift_one
        assign vld_shift = issue;
    end else begin : g_shift_many
        assign vld_shift = {vld_q[PARM_STAGES-2:0], issue};
    end

    // -------------------------------------------------------------------------
    // Stage registers: valid, tag and source travel together
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q    <= '0;
            src_q    <= '0;
            rr_ptr_q <= 1'b0;
            for (int k = 0; k < PARM_STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (flush_w) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q <= vld_shift;
            end

            if (adv || flush_w) begin
                tag_q[0] <= grant_tag;
                src_q[0] <= grant;
                for (int k = 1; k < PARM_STAGES; k++) begin
                    tag_q[k] <= tag_q[k-1];
                    src_q[k] <= src_q[k-1];
                end
            end

            // The pointer moves only when something is actually issued, so a
            // stalled or flushed cycle does not cost a requester its turn.
            if (issue) begin
                rr_ptr_q <= ~grant;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dp_issue_o   = issue;
    assign dp_sel_o     = issue & grant;
    assign req0_ready_o = issue & ~grant;
    assign req1_ready_o = issue &  grant;
    assign stage_en_o   = {PARM_STAGES{~rst_i & (adv | flush_w)}};

    assign res_valid_o  = vld_q[PARM_STAGES-1];
    assign res_tag_o    = tag_q[PARM_STAGES-1];
    assign res_src_o    = src_q[PARM_STAGES-1];
    assign busy_o       = |vld_q;

endmodule

// File: tb/tb_mac_pipe_sched.sv
module tb_mac_pipe_sched;

    localparam int NS = 3;
    localparam int TW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req0_valid_i;
    logic [TW-1:0] req0_tag_i;
    logic          req0_ready_o;
    logic          req1_valid_i;
    logic [TW-1:0] req1_tag_i;
    logic          req1_ready_o;
    logic          dp_sel_o;
    logic          dp_issue_o;
    logic [NS-1:0] stage_en_o;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [TW-1:0] res_tag_o;
    logic          res_src_o;
    logic          busy_o;
`ifdef MAC_SCHED_FLUSH_EN
    logic          flush_i;
`endif

    mac_pipe_sched #(
        .PARM_MANT   (23),
        .PARM_STAGES (NS),
        .PARM_TAG_W  (TW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_tag_i   (req0_tag_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_tag_i   (req1_tag_i),
        .req1_ready_o (req1_ready_o),
        .dp_sel_o     (dp_sel_o),
        .dp_issue_o   (dp_issue_o),
        .stage_en_o   (stage_en_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_tag_o    (res_tag_o),
        .res_src_o    (res_src_o),
`ifdef MAC_SCHED_FLUSH_EN
        .flush_i      (flush_i),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_cmp = 0;
    int            n_err = 0;

    // Reference state: occupancy of the three stages, round-robin pointer,
    // expected results in issue order ({src, tag}).
    logic [NS-1:0] m_vld;
    logic          m_rr;
    logic [TW:0]   sb [$];
    logic          m_flush;
    logic          obs_sel;

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ready0"},   {7'd0, req0_ready_o}, 8'd0);
        chk({pfx, "_ready1"},   {7'd0, req1_ready_o}, 8'd0);
        chk({pfx, "_issue"},    {7'd0, dp_issue_o},   8'd0);
        chk({pfx, "_sel"},      {7'd0, dp_sel_o},     8'd0);
        chk({pfx, "_stage_en"}, {5'd0, stage_en_o},   8'd0);
        chk({pfx, "_res_vld"},  {7'd0, res_valid_o},  8'd0);
        chk({pfx, "_res_tag"},  {4'd0, res_tag_o},    8'd0);
        chk({pfx, "_res_src"},  {7'd0, res_src_o},    8'd0);
        chk({pfx, "_busy"},     {7'd0, busy_o},       8'd0);
    endtask

    // One clock cycle. Entered 1 time unit after a rising edge; drives the
    // inputs, samples mid-cycle, then advances to 1 unit after the next edge.
    task automatic cyc(input logic v0, input logic [TW-1:0] t0,
                       input logic v1, input logic [TW-1:0] t1,
                       input logic rr);
        logic          adv;
        logic          exp_grant;
        logic          exp_issue;
        logic [TW:0]   head;
        req0_valid_i = v0;
        req0_tag_i   = t0;
        req1_valid_i = v1;
        req1_tag_i   = t1;
        res_ready_i  = rr;
`ifdef MAC_SCHED_FLUSH_EN
        flush_i      = m_flush;
`endif
        #3;
        adv       = ~(m_vld[NS-1] & ~rr);
        exp_grant = (v0 && v1) ? m_rr : v1;
        exp_issue = adv & (v0 | v1) & ~m_flush;
        obs_sel   = dp_sel_o;
        chk("issue",    {7'd0, dp_issue_o},   {7'd0, exp_issue});
        chk("ready0",   {7'd0, req0_ready_o}, {7'd0, exp_issue & ~exp_grant});
        chk("ready1",   {7'd0, req1_ready_o}, {7'd0, exp_issue &  exp_grant});
        chk("stage_en", {5'd0, stage_en_o},   {5'd0, {NS{adv | m_flush}}});
        chk("res_valid",{7'd0, res_valid_o},  {7'd0, m_vld[NS-1]});
        chk("busy",     {7'd0, busy_o},       {7'd0, |m_vld});
        if (exp_issue) begin
            chk("sel", {7'd0, dp_sel_o}, {7'd0, exp_grant});
            sb.push_back({exp_grant, exp_grant ? t1 : t0});
        end
        if (m_vld[NS-1]) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_empty: observed result tag %0h expected no result", res_tag_o);
            end else begin
                head = sb[0];
                chk("res_tag", {4'd0, res_tag_o}, {4'd0, head[TW-1:0]});
                chk("res_src", {7'd0, res_src_o}, {7'd0, head[TW]});
                if (rr) void'(sb.pop_front());
            end
        end
        @(posedge clk_i);
        #1;
        if (m_flush) begin
            m_vld = '0;
            sb.delete();
        end else if (adv) begin
            m_vld = {m_vld[NS-2:0], exp_issue};
        end
        if (exp_issue) m_rr = ~exp_grant;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_vld = '0;
        m_rr  = 1'b0;
        sb.delete();
    endtask

    initial begin
        logic [TW-1:0] t0n;
        logic [TW-1:0] t1n;
        rst_i        = 1'b1;
        req0_valid_i = 1'b0;
        req0_tag_i   = '0;
        req1_valid_i = 1'b0;
        req1_tag_i   = '0;
        res_ready_i  = 1'b0;
        m_flush      = 1'b0;
`ifdef MAC_SCHED_FLUSH_EN
        flush_i      = 1'b0;
`endif
        m_vld        = '0;
        m_rr         = 1'b0;
        obs_sel      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_i = 1'b0;

        // Single op from requester 0, tag 5: result exactly three cycles later.
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 1'b1);
        idle(5);

        // Reset with two operations in flight and a request still pending.
        cyc(1'b1, 4'd1, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
        rst_i        = 1'b1;
        req0_valid_i = 1'b1;
        req0_tag_i   = 4'd3;
        #1;
        chk_all_zero("midrst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_vld = '0;
        m_rr  = 1'b0;
        sb.delete();
        idle(5);

        // Contention from reset: grants alternate starting with requester 0.
        do_reset();
        t0n = 4'h1;
        t1n = 4'h8;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, t0n, 1'b1, t1n, 1'b1);
            chk("cont_grant", {7'd0, obs_sel}, (i % 2 == 0) ? 8'd0 : 8'd1);
            if (obs_sel) t1n = t1n + 4'd1;
            else         t0n = t0n + 4'd1;
        end
        idle(4);

        // Backpressure: three ops, consumer stalls for four cycles while both
        // requesters wait, then releases.
        do_reset();
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 4'd9, 1'b1);
        cyc(1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'd6, 1'b1, 4'hA, 1'b0);
        cyc(1'b1, 4'd6, 1'b1, 4'hA, 1'b1);
        idle(5);

        // Full pipe, result popped and a new op issued in the same cycle.
        do_reset();
        cyc(1'b1, 4'd1, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 4'd4, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        idle(4);

`ifdef MAC_SCHED_FLUSH_EN
        // Flush while a second op is requested: nothing further completes.
        do_reset();
        cyc(1'b1, 4'd7, 1'b0, 4'd0, 1'b1);
        m_flush = 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 4'd8, 1'b1);
        m_flush = 1'b0;
        chk("flush_busy", {7'd0, busy_o}, 8'd0);
        idle(5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
